// File: rtl/file_byte_viewer_if.sv
// Byte stream from the SD file reader.
// One byte per cycle while in_en is high; there is no backpressure.
interface file_byte_viewer_if;
  logic       in_en;
  logic [7:0] in_byte;

  modport master (
    output in_en,
    output in_byte
  );

  modport slave (
    input in_en,
    input in_byte
  );
endinterface

// File: rtl/file_byte_viewer.sv
// Captures file bytes into a buffer and shows index/value in hex
// on a 4-digit multiplexed 7-segment display, stepped by a button.
module file_byte_viewer #(
  parameter int DEPTH_AW     = 10,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int SCAN_CYC     = 25000
) (
  input  logic                clk,
  input  logic                rst,
  file_byte_viewer_if.slave   s,
  input  logic                next,
  output logic [DEPTH_AW:0]   buf_count,
  output logic                overflow,
  output logic [3:0]          an,
  output logic [6:0]          seg
);

  localparam int DEPTH = 2 ** DEPTH_AW;
  localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int SC_W  = $clog2(SCAN_CYC + 1);
  localparam logic [DEPTH_AW:0] FULL = (DEPTH_AW + 1)'(DEPTH);
  localparam logic [DB_W-1:0]   DB_TC = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [SC_W-1:0]   SC_TC = SC_W'(SCAN_CYC - 1);
  localparam logic [6:0]        DASH = 7'b0111111;

  logic [7:0]          mem_q [DEPTH];
  logic [7:0]          view_byte_q;

  logic [DEPTH_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_AW:0]   cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                wr_en;

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
  logic                db_lvl_q, db_lvl_d;
  logic                step_q, step_d;

  logic [DEPTH_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_AW:0]   rd_inc;

  logic [SC_W-1:0]     scan_q, scan_d;
  logic [1:0]          dig_q, dig_d;
  logic [3:0]          an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic [7:0]          idx8;
  logic [3:0]          nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] r;
    unique case (n)
      4'h0: r = 7'b1000000;
      4'h1: r = 7'b1111001;
      4'h2: r = 7'b0100100;
      4'h3: r = 7'b0110000;
      4'h4: r = 7'b0011001;
      4'h5: r = 7'b0010010;
      4'h6: r = 7'b0000010;
      4'h7: r = 7'b1111000;
      4'h8: r = 7'b0000000;
      4'h9: r = 7'b0010000;
      4'hA: r = 7'b0001000;
      4'hB: r = 7'b0000011;
      4'hC: r = 7'b1000110;
      4'hD: r = 7'b0100001;
      4'hE: r = 7'b0000110;
      default: r = 7'b0001110;
    endcase
    return r;
  endfunction

  // Capture path
  always_comb begin
    wr_en    = s.in_en && (cnt_q != FULL);
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + DEPTH_AW'(1);
      cnt_d    = cnt_q + (DEPTH_AW + 1)'(1);
    end else if (s.in_en) begin
      ovf_d = 1'b1;
    end
  end

  // Button synchronizer, debounce and rising-edge step
  always_comb begin
    sync1_d  = next;
    sync2_d  = sync1_q;
    db_lvl_d = db_lvl_q;
    db_cnt_d = '0;
    if (sync2_q != db_lvl_q) begin
      if (db_cnt_q == DB_TC) begin
        db_lvl_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
    step_d = db_lvl_d & ~db_lvl_q;
  end

  // Wrap compares against the count before any same-cycle capture
  always_comb begin
    rd_inc   = {1'b0, rd_ptr_q} + (DEPTH_AW + 1)'(1);
    rd_ptr_d = rd_ptr_q;
    if (step_q && (cnt_q != '0)) begin
      rd_ptr_d = (rd_inc == cnt_q) ? '0 : rd_inc[DEPTH_AW-1:0];
    end
  end

  always_comb begin
    scan_d = (scan_q == SC_TC) ? '0 : scan_q + SC_W'(1);
    dig_d  = (scan_q == SC_TC) ? dig_q + 2'd1 : dig_q;
    idx8   = 8'(rd_ptr_q);
    unique case (dig_q)
      2'd0:    nib = view_byte_q[3:0];
      2'd1:    nib = view_byte_q[7:4];
      2'd2:    nib = idx8[3:0];
      default: nib = idx8[7:4];
    endcase
    an_d  = ~(4'b0001 << dig_q);
    seg_d = (cnt_q == '0) ? DASH : hex7(nib);
  end

  // Buffer RAM is never cleared; buf_count gates what is visible
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= s.in_byte;
    end
    view_byte_q <= mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_cnt_q <= '0;
      db_lvl_q <= 1'b0;
      step_q   <= 1'b0;
      rd_ptr_q <= '0;
      scan_q   <= '0;
      dig_q    <= '0;
      an_q     <= 4'b1111;
      seg_q    <= 7'b1111111;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_cnt_q <= db_cnt_d;
      db_lvl_q <= db_lvl_d;
      step_q   <= step_d;
      rd_ptr_q <= rd_ptr_d;
      scan_q   <= scan_d;
      dig_q    <= dig_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign buf_count = cnt_q;
  assign overflow  = ovf_q;
  assign an        = an_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_file_byte_viewer.sv
// Bench for file_byte_viewer: scoreboard of expected index/byte views
// plus a table of hex-encoding vectors over a full 16-byte buffer.
module tb_file_byte_viewer;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           next;
  logic [AW:0]    buf_count;
  logic           overflow;
  logic [3:0]     an;
  logic [6:0]     seg;

  file_byte_viewer_if bus ();

  file_byte_viewer #(
    .DEPTH_AW    (AW),
    .DEBOUNCE_CYC(8),
    .SCAN_CYC    (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s        (bus.slave),
    .next     (next),
    .buf_count(buf_count),
    .overflow (overflow),
    .an       (an),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] DASH = 7'b0111111;

  typedef struct {
    logic [7:0] b;
    logic [6:0] s0;
    logic [6:0] s1;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] b;
  } exp_t;

  vec_t vt [16];
  exp_t sbq [$];

  int tests = 0;
  int fails = 0;

  logic [7:0] mem_m [DEPTH];
  int cnt_m = 0;
  int rd_m = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_digit(input string nm, input int d,
                             input logic [6:0] exp);
    logic [3:0] want;
    bit found;
    want = ~(4'b0001 << d);
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (an === want) found = 1;
    end
    if (found) begin
      chk(nm, {25'd0, seg}, {25'd0, exp});
    end else begin
      tests++;
      fails++;
      $display("FAIL %s: digit %0d never scanned, an=%b", nm, d, an);
    end
  endtask

  task automatic check_dash(input string nm);
    for (int d = 0; d < 4; d++) check_digit(nm, d, DASH);
  endtask

  task automatic check_view(input string nm);
    exp_t e;
    logic [7:0] ix;
    tick(4);
    if (sbq.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty, got nothing expected entry", nm);
      return;
    end
    e = sbq.pop_front();
    ix = 8'(e.idx);
    check_digit({nm, "_d0"}, 0, HEX[e.b[3:0]]);
    check_digit({nm, "_d1"}, 1, HEX[e.b[7:4]]);
    check_digit({nm, "_d2"}, 2, HEX[ix[3:0]]);
    check_digit({nm, "_d3"}, 3, HEX[ix[7:4]]);
  endtask

  task automatic expect_cur();
    exp_t e;
    e.idx = rd_m;
    e.b = mem_m[rd_m];
    sbq.push_back(e);
  endtask

  task automatic model_step();
    if (cnt_m != 0) rd_m = (rd_m + 1 == cnt_m) ? 0 : rd_m + 1;
    expect_cur();
  endtask

  task automatic cap(input logic [7:0] b);
    bus.in_en = 1'b1;
    bus.in_byte = b;
    tick(1);
    bus.in_en = 1'b0;
    if (cnt_m < DEPTH) begin
      mem_m[cnt_m] = b;
      cnt_m++;
    end
  endtask

  task automatic press();
    next = 1'b1;
    tick(20);
    next = 1'b0;
    tick(20);
    model_step();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    tick(n);
    rst = 1'b0;
    cnt_m = 0;
    rd_m = 0;
  endtask

  initial begin
    bit found;
    vt[0]  = '{8'hF0, 7'b1000000, 7'b0001110};
    vt[1]  = '{8'hE1, 7'b1111001, 7'b0000110};
    vt[2]  = '{8'hD2, 7'b0100100, 7'b0100001};
    vt[3]  = '{8'hC3, 7'b0110000, 7'b1000110};
    vt[4]  = '{8'hB4, 7'b0011001, 7'b0000011};
    vt[5]  = '{8'hA5, 7'b0010010, 7'b0001000};
    vt[6]  = '{8'h96, 7'b0000010, 7'b0010000};
    vt[7]  = '{8'h87, 7'b1111000, 7'b0000000};
    vt[8]  = '{8'h78, 7'b0000000, 7'b1111000};
    vt[9]  = '{8'h69, 7'b0010000, 7'b0000010};
    vt[10] = '{8'h5A, 7'b0001000, 7'b0010010};
    vt[11] = '{8'h4B, 7'b0000011, 7'b0011001};
    vt[12] = '{8'h3C, 7'b1000110, 7'b0110000};
    vt[13] = '{8'h2D, 7'b0100001, 7'b0100100};
    vt[14] = '{8'h1E, 7'b0000110, 7'b1111001};
    vt[15] = '{8'h0F, 7'b0001110, 7'b1000000};

    rst = 1'b1;
    next = 1'b0;
    bus.in_en = 1'b0;
    bus.in_byte = 8'h00;
    tick(3);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_cnt", {27'd0, buf_count}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    rst = 1'b0;

    // Idle scan: digit enables rotate every 4 cycles, all dashes
    found = 0;
    for (int i = 0; i < 32 && !found; i++) begin
      @(negedge clk);
      if (an === 4'b1110) found = 1;
    end
    chk("scan_start", {31'd0, found}, 1);
    chk("scan_seg0", {25'd0, seg}, {25'd0, DASH});
    for (int k = 1; k <= 4; k++) begin
      logic [3:0] w;
      w = ~(4'b0001 << (k % 4));
      tick(4);
      chk("scan_an", {28'd0, an}, {28'd0, w});
      chk("scan_seg", {25'd0, seg}, {25'd0, DASH});
    end

    // Two bytes, view at index 0
    cap(8'h48);
    cap(8'h69);
    tick(1);
    chk("cap2_cnt", {27'd0, buf_count}, 2);
    expect_cur();
    check_view("cap2");

    press();
    check_view("step1");
    press();
    check_view("wrap0");

    // Bouncy press then a clean hold: exactly one step, none on release
    for (int i = 0; i < 10; i++) begin
      next = ~next;
      tick(3);
    end
    next = 1'b1;
    tick(20);
    model_step();
    check_view("bounce_hold");
    next = 1'b0;
    tick(30);
    expect_cur();
    check_view("bounce_rel");

    // Full buffer walked through the hex table, then overflow
    do_reset(2);
    chk("r2_cnt", {27'd0, buf_count}, 0);
    check_dash("r2_dash");
    for (int i = 0; i < 16; i++) cap(vt[i].b);
    tick(1);
    chk("full_cnt", {27'd0, buf_count}, 16);
    chk("full_ovf", {31'd0, overflow}, 0);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] n;
      n = 4'(i);
      if (i > 0) press();
      tick(4);
      check_digit("tbl_d0", 0, vt[i].s0);
      check_digit("tbl_d1", 1, vt[i].s1);
      check_digit("tbl_d2", 2, HEX[n]);
      check_digit("tbl_d3", 3, HEX[0]);
    end
    sbq.delete();
    cap(8'hAA);
    tick(1);
    chk("ovf_set", {31'd0, overflow}, 1);
    chk("ovf_cnt", {27'd0, buf_count}, 16);
    press();
    check_view("ovf_wrap");
    tick(5);
    chk("ovf_hold", {31'd0, overflow}, 1);

    do_reset(1);
    chk("r3_ovf", {31'd0, overflow}, 0);
    chk("r3_cnt", {27'd0, buf_count}, 0);
    check_dash("r3_dash");

    // Step coinciding with a capture wraps against the old count
    cap(8'h11);
    next = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (dut.step_q === 1'b1) found = 1;
    end
    chk("coinc_step", {31'd0, found}, 1);
    bus.in_en = 1'b1;
    bus.in_byte = 8'h22;
    tick(1);
    bus.in_en = 1'b0;
    mem_m[1] = 8'h22;
    cnt_m = 2;
    rd_m = 0;
    next = 1'b0;
    tick(30);
    chk("coinc_cnt", {27'd0, buf_count}, 2);
    expect_cur();
    check_view("coinc_view");
    press();
    check_view("coinc_next");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
